// File: rtl/da_result_sink.sv
// da_result_sink: buffers fixed-latency dA multiplier results in a FWFT FIFO, returns issue credit, tags beats with tile index.
module da_result_sink #(
  parameter int DW        = 16,
  parameter int H_TILE    = 1,
  parameter int DEPTH     = 8,
  parameter int NUM_TILES = 24,
  parameter int IDXW      = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 issue_i,
  input  logic                 res_valid_i,
  input  logic [H_TILE*DW-1:0] res_data_i,
  output logic                 can_issue_o,
  output logic                 m_valid_o,
  output logic [H_TILE*DW-1:0] m_data_o,
  output logic [IDXW-1:0]      m_idx_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i,
  output logic                 ovf_err_o,
  output logic                 unexp_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = H_TILE * DW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_TILES - 1);

  logic [BW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]     cnt_q, cnt_d, inf_q, inf_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            ovf_q, ovf_d, unexp_q, unexp_d, pop, wr_en;

  always_comb begin
    pop     = (cnt_q != '0) && m_ready_i;
    wr_en   = res_valid_i && ((cnt_q != FULL) || pop);
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
    cnt_d   = (wr_en && !pop) ? cnt_q + (AW+1)'(1) : (pop && !wr_en) ? cnt_q - (AW+1)'(1) : cnt_q;
    ovf_d   = ovf_q || (res_valid_i && (cnt_q == FULL) && !pop);
    idx_d   = !pop ? idx_q : (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
    inf_d   = inf_q;
    unexp_d = unexp_q;
    if (issue_i && !res_valid_i)
      inf_d = (inf_q == FULL) ? inf_q : inf_q + (AW+1)'(1);
    else if (res_valid_i && !issue_i) begin
      unexp_d = unexp_q || (inf_q == '0);
      inf_d   = (inf_q == '0) ? inf_q : inf_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      inf_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      inf_q   <= inf_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      unexp_q <= unexp_d;
    end
  end

  // Storage is not reset; the output mux masks stale contents while empty.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem_q[wr_q] <= res_data_i;
  end

  assign can_issue_o = ({1'b0, cnt_q} + {1'b0, inf_q}) < (AW+2)'(DEPTH);
  assign m_valid_o   = cnt_q != '0;
  assign m_data_o    = m_valid_o ? mem_q[rd_q] : '0;
  assign m_idx_o     = idx_q;
  assign m_last_o    = idx_q == LAST_IDX;
  assign ovf_err_o   = ovf_q;
  assign unexp_err_o = unexp_q;
endmodule
